// File: rtl/jtag_master.sv
// JTAG master: runs TAP-reset, IR and IR+DR scans from one system clock; tck = clk/(2*DIV).
// tms/tdi launch on the clk edge that drops tck, tdo is captured on the edge that raises it.
module jtag_master #(
  parameter int DIV   = 4,
  parameter int DRMAX = 96
) (
  input  logic             clk,
  input  logic             hard_rst,
  input  logic             start,
  input  logic             tlr_req,
  input  logic [4:0]       ir_code,
  input  logic [9:0]       dr_len,
  input  logic [DRMAX-1:0] dr_in,
  output logic             tck,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo,
  output logic             busy,
  output logic             done,
  output logic [4:0]       ir_out,
  output logic [DRMAX-1:0] dr_out
);

  localparam int         IW      = (DRMAX > 1) ? $clog2(DRMAX) : 1;
  localparam logic [9:0] NMAX    = 10'(DRMAX);
  localparam logic [7:0] DIV_TOP = 8'(DIV - 1);

  typedef enum logic [3:0] {
    IDLE, TLR, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, FIN
  } state_t;

  state_t           state_q, state_d, ns;
  logic [9:0]       cnt_q, cnt_d, nc;
  logic [9:0]       n_q, n_d;
  logic [7:0]       div_q, div_d;
  logic             tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [4:0]       ir_code_q, ir_code_d, ir_out_q, ir_out_d;
  logic [DRMAX-1:0] dr_in_q, dr_in_d, dr_out_q, dr_out_d;
  logic             load;
  logic [IW-1:0]    k_cap, k_lnch;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    div_d     = div_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ir_code_d = ir_code_q;
    ir_out_d  = ir_out_q;
    dr_in_d   = dr_in_q;
    dr_out_d  = dr_out_q;
    load      = 1'b0;
    ns        = state_q;
    nc        = cnt_q;
    k_cap     = IW'(n_q - 10'd1 - cnt_q);
    k_lnch    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ir_code_d = ir_code;
          dr_in_d   = dr_in;
          n_d       = (dr_len > NMAX) ? NMAX : dr_len;
          for (int i = 0; i < DRMAX; i++) begin
            if (10'(i) >= n_d) dr_out_d[i] = 1'b0;
          end
          busy_d = 1'b1;
          div_d  = DIV_TOP;
          tck_d  = 1'b0;
          load   = 1'b1;
          ns     = tlr_req ? TLR : IR_HDR;
          nc     = tlr_req ? 10'd5 : 10'd3;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DIV_TOP;
          tck_d = ~tck_q;
          if (!tck_q) begin
            // rising tck: target launched tdo on the previous falling edge
            if (state_q == IR_SHIFT) ir_out_d[3'd4 - cnt_q[2:0]] = tdo;
            if (state_q == DR_SHIFT) dr_out_d[k_cap] = tdo;
          end else begin
            load = 1'b1;
            if (cnt_q != 10'd0) begin
              nc = cnt_q - 10'd1;
            end else begin
              case (state_q)
                TLR:      ns = FIN;
                IR_HDR:   begin ns = IR_SHIFT; nc = 10'd4;        end
                IR_SHIFT: begin ns = IR_TAIL;  nc = 10'd1;        end
                IR_TAIL:  begin ns = (n_q == 10'd0) ? FIN : DR_HDR; nc = 10'd2; end
                DR_HDR:   begin ns = DR_SHIFT; nc = n_q - 10'd1;  end
                DR_SHIFT: begin ns = DR_TAIL;  nc = 10'd1;        end
                default:  ns = FIN;
              endcase
            end
          end
        end
      end
    endcase

    // cnt counts down within a state, so each step's tms/tdi is a function of (state, cnt)
    if (load) begin
      state_d = ns;
      cnt_d   = nc;
      tms_d   = 1'b0;
      tdi_d   = 1'b0;
      k_lnch  = IW'(n_d - 10'd1 - nc);
      case (ns)
        TLR:      tms_d = (nc != 10'd0);
        IR_HDR:   tms_d = (nc >= 10'd2);
        IR_SHIFT: begin
          tms_d = (nc == 10'd0);
          tdi_d = ir_code_d[3'd4 - nc[2:0]];
        end
        IR_TAIL,
        DR_TAIL:  tms_d = (nc == 10'd1);
        DR_HDR:   tms_d = (nc == 10'd2);
        DR_SHIFT: begin
          tms_d = (nc == 10'd0);
          tdi_d = dr_in_d[k_lnch];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      div_q     <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b0;
      tdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ir_code_q <= '0;
      ir_out_q  <= '0;
      dr_in_q   <= '0;
      dr_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      div_q     <= div_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ir_code_q <= ir_code_d;
      ir_out_q  <= ir_out_d;
      dr_in_q   <= dr_in_d;
      dr_out_q  <= dr_out_d;
    end
  end

  assign tck    = tck_q;
  assign tms    = tms_q;
  assign tdi    = tdi_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign ir_out = ir_out_q;
  assign dr_out = dr_out_q;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master with a behavioural target TAP (IDCODE, ParamReg, bypass).
module tb_jtag_master;
  localparam int DRMAX = 96;
  localparam logic [39:0] IDCODE = 40'h12_3456_789A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             hard_rst, start, s_start, tlr_req;
  logic             tdo = 1'b0;
  logic [4:0]       ir_code;
  logic [9:0]       dr_len;
  logic [DRMAX-1:0] dr_in;
  logic             tck, tms, tdi, busy, done;
  logic [4:0]       ir_out;
  logic [DRMAX-1:0] dr_out;
  logic             s_tck, s_tms, s_tdi, s_busy, s_done;
  logic [4:0]       s_ir_out;
  logic [DRMAX-1:0] s_dr_out;

  jtag_master #(.DIV(1), .DRMAX(DRMAX)) u_dut (
    .clk(clk), .hard_rst(hard_rst), .start(start), .tlr_req(tlr_req),
    .ir_code(ir_code), .dr_len(dr_len), .dr_in(dr_in),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .busy(busy), .done(done), .ir_out(ir_out), .dr_out(dr_out)
  );

  jtag_master #(.DIV(3), .DRMAX(DRMAX)) u_slow (
    .clk(clk), .hard_rst(hard_rst), .start(s_start), .tlr_req(tlr_req),
    .ir_code(ir_code), .dr_len(dr_len), .dr_in(dr_in),
    .tck(s_tck), .tms(s_tms), .tdi(s_tdi), .tdo(1'b0),
    .busy(s_busy), .done(s_done), .ir_out(s_ir_out), .dr_out(s_dr_out)
  );

  // ---------------- target TAP model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
  } tap_t;

  tap_t         tap_st   = T_SHDR;
  logic [4:0]   t_ir     = 5'd31;
  logic [4:0]   ir_sh    = 5'd0;
  logic [39:0]  dsh      = 40'd0;
  logic [8:0]   param    = 9'd0;
  int           rise_cnt = 0;
  int           shdr_cnt = 0;
  logic [127:0] tms_log  = '0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDR  : T_PADR;
      T_PADR:  return m ? T_EX2DR : T_PADR;
      T_EX2DR: return m ? T_UPDR  : T_SHDR;
      T_UPDR:  return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPIR  : T_PAIR;
      T_PAIR:  return m ? T_EX2IR : T_PAIR;
      T_EX2IR: return m ? T_UPIR  : T_SHIR;
      default: return m ? T_SELDR : T_RTI;
    endcase
  endfunction

  function automatic int dr_len_of(input logic [4:0] ir);
    case (ir)
      5'd0:         return 40;
      5'd21, 5'd22: return 9;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [39:0] dshift(input logic [39:0] v, input logic b, input int len);
    logic [39:0] r;
    r = v >> 1;
    r[len-1] = b;
    return r;
  endfunction

  always @(posedge tck) begin
    rise_cnt <= rise_cnt + 1;
    tms_log  <= {tms_log[126:0], tms};
    tap_st   <= tap_next(tap_st, tms);
    case (tap_st)
      T_TLR:   t_ir  <= 5'd31;
      T_CAPIR: ir_sh <= 5'b00001;
      T_SHIR:  ir_sh <= {tdi, ir_sh[4:1]};
      T_UPIR:  t_ir  <= ir_sh;
      T_CAPDR: dsh   <= (t_ir == 5'd0) ? IDCODE :
                        (t_ir == 5'd21 || t_ir == 5'd22) ? {31'd0, param} : 40'd0;
      T_SHDR: begin
        dsh      <= dshift(dsh, tdi, dr_len_of(t_ir));
        shdr_cnt <= shdr_cnt + 1;
      end
      T_UPDR:  if (t_ir == 5'd22) param <= dsh[8:0];
      default: ;
    endcase
  end

  always @(negedge tck)
    tdo <= (tap_st == T_SHIR) ? ir_sh[0] : (tap_st == T_SHDR) ? dsh[0] : 1'b0;

  int done_cnt = 0;
  int s_hi     = 0;
  int s_rise   = 0;
  logic [7:0] s_tms_log = '0;
  always @(negedge clk) begin
    if (done)  done_cnt <= done_cnt + 1;
    if (s_tck) s_hi     <= s_hi + 1;
  end
  always @(posedge s_tck) begin
    s_rise    <= s_rise + 1;
    s_tms_log <= {s_tms_log[6:0], s_tms};
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start, waits (bounded) for done; optionally re-pulses start mid-sequence.
  task automatic run_seq(input int poke_at, output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_set", busy, 1'b1);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (poke_at != 0 && cyc == poke_at) begin
        start = 1'b1; tlr_req = 1'b1; dr_in = ~dr_in; dr_len = 10'd3;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_seen", done, 1'b1);
    @(negedge clk);
    chk("done_1clk", done, 1'b0);
    chk("busy_clr", busy, 1'b0);
  endtask

  int cyc, b, s, d0, k;
  logic [DRMAX-1:0] saved;

  initial begin
    hard_rst = 1'b0; start = 1'b0; s_start = 1'b0; tlr_req = 1'b0;
    ir_code = '0; dr_len = '0; dr_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 1'b0);   chk("rst_tms", tms, 1'b0);   chk("rst_tdi", tdi, 1'b0);
    chk("rst_busy", busy, 1'b0); chk("rst_done", done, 1'b0);
    chk("rst_ir_out", ir_out, 5'd0); chk("rst_dr_out", dr_out, '0);
    hard_rst = 1'b1;
    @(negedge clk);

    // TAP reset sequence
    tlr_req = 1'b1; b = rise_cnt;
    run_seq(0, cyc);
    chk("tlr_lat", cyc, 13);
    chk("tlr_rises", rise_cnt - b, 6);
    chk("tlr_tms", tms_log[5:0], 6'b111110);
    chk("tlr_tap_rti", tap_st, T_RTI);
    chk("tlr_tck_low", tck, 1'b0);

    // IDCODE read
    tlr_req = 1'b0; ir_code = 5'd0; dr_len = 10'd40; dr_in = '0; b = rise_cnt;
    run_seq(0, cyc);
    chk("id_dr_out", dr_out, 96'(IDCODE));
    chk("id_ir_out", ir_out, 5'b00001);
    chk("id_tgt_ir", t_ir, 5'd0);
    chk("id_lat", cyc, 113);
    chk("id_rises", rise_cnt - b, 56);

    // ParamReg write (bits above n must be cleared at start)
    ir_code = 5'd22; dr_len = 10'd9; dr_in = 96'h1FD;
    run_seq(0, cyc);
    chk("pw_param", param, 9'h1FD);
    chk("pw_dr_out", dr_out, '0);
    chk("pw_tap_rti", tap_st, T_RTI);

    // ParamReg readback
    ir_code = 5'd21; dr_in = '0;
    run_seq(0, cyc);
    chk("pr_dr_out", dr_out, 96'h1FD);
    chk("pr_tgt_ir", t_ir, 5'd21);
    chk("pr_param", param, 9'h1FD);

    // IR-only scan
    ir_code = 5'd31; dr_len = 10'd0; dr_in = '1; b = rise_cnt; s = shdr_cnt;
    run_seq(0, cyc);
    chk("iro_rises", rise_cnt - b, 11);
    chk("iro_lat", cyc, 23);
    chk("iro_dr_out", dr_out, '0);
    chk("iro_tgt_ir", t_ir, 5'd31);
    chk("iro_tap_rti", tap_st, T_RTI);
    chk("iro_no_shdr", shdr_cnt - s, 0);

    // saturated DR length through bypass, with an ignored mid-scan start
    dr_len = 10'd1000; dr_in = {32'hDEADBEEF, 32'h0123_4567, 32'h89AB_CDEF};
    saved = dr_in; b = rise_cnt; s = shdr_cnt;
    run_seq(50, cyc);
    chk("sat_shifts", shdr_cnt - s, 96);
    chk("sat_rises", rise_cnt - b, 112);
    chk("sat_lat", cyc, 225);
    chk("sat_dr_out", dr_out, {saved[94:0], 1'b0});
    chk("sat_tap_rti", tap_st, T_RTI);

    // hard reset in the middle of DR_SHIFT
    tlr_req = 1'b0; ir_code = 5'd31; dr_len = 10'd96; dr_in = saved; s = shdr_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (shdr_cnt - s < 20 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("ab_in_shdr", tap_st, T_SHDR);
    d0 = done_cnt;
    hard_rst = 1'b0;
    #1;
    chk("ab_tck", tck, 1'b0);   chk("ab_tms", tms, 1'b0);   chk("ab_tdi", tdi, 1'b0);
    chk("ab_busy", busy, 1'b0); chk("ab_done", done, 1'b0);
    chk("ab_ir_out", ir_out, 5'd0); chk("ab_dr_out", dr_out, '0);
    repeat (3) @(negedge clk);
    hard_rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("ab_no_done", done_cnt - d0, 0);
    tlr_req = 1'b1; b = rise_cnt;
    run_seq(0, cyc);
    chk("ab_tlr_lat", cyc, 13);
    chk("ab_tlr_rises", rise_cnt - b, 6);
    chk("ab_tap_rti", tap_st, T_RTI);

    // DIV=3 instance: tck timing
    tlr_req = 1'b1; dr_len = 10'd0; b = s_rise; s = s_hi;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    cyc = 0;
    while (!s_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("slow_done", s_done, 1'b1);
    chk("slow_lat", cyc, 37);
    chk("slow_rises", s_rise - b, 6);
    chk("slow_tms", s_tms_log[5:0], 6'b111110);
    chk("slow_hi_cycles", s_hi - s, 18);
    @(negedge clk);
    chk("slow_busy", s_busy, 1'b0);
    chk("slow_tdi", s_tdi, 1'b0);
    chk("slow_tck", s_tck, 1'b0);
    chk("slow_ir_out", s_ir_out, 5'd0);
    chk("slow_dr_out", s_dr_out, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
